// File: rtl/alu_issue_if.sv
// Handshake and ALU-side bundle between the issue controller and its environment.
// The slave modport is the controller's view; master is the producer/consumer/ALU side.
interface alu_issue_if #(
   parameter int WIDTH = 32
);
   logic             req_valid;
   logic             req_ready;
   logic [WIDTH-1:0] req_a;
   logic [WIDTH-1:0] req_b;
   logic [2:0]       req_op;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [2:0]       alu_op;
   logic             alu_rst;
   logic [WIDTH-1:0] alu_result;
   logic             alu_cout;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] rsp_result;
   logic             rsp_cout;
   logic             busy;

   modport slave (
      input  req_valid, req_a, req_b, req_op, alu_result, alu_cout, rsp_ready,
      output req_ready, alu_a, alu_b, alu_op, alu_rst, rsp_valid, rsp_result, rsp_cout, busy
   );

   modport master (
      output req_valid, req_a, req_b, req_op, alu_result, alu_cout, rsp_ready,
      input  req_ready, alu_a, alu_b, alu_op, alu_rst, rsp_valid, rsp_result, rsp_cout, busy
   );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue stage for the multi-cycle ALU: latches one request, holds operands stable,
// restarts the iterative mod via a one-cycle ALU reset, waits a fixed count, captures the result.
module alu_issue_ctrl #(
   parameter int WIDTH         = 32,
   parameter int MOD_CYCLES    = 16,
   parameter int SIMPLE_CYCLES = 1
) (
   input logic        CLK,
   input logic        reset,
   alu_issue_if.slave bus
);
   localparam int MAXC = (MOD_CYCLES > SIMPLE_CYCLES) ? MOD_CYCLES : SIMPLE_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);

   typedef enum logic [1:0] {IDLE, ARM, WAIT, HOLD} state_t;

   state_t        state;
   logic          arm_q;
   logic [CW-1:0] cnt;

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         arm_q          <= 1'b0;
         cnt            <= '0;
         bus.alu_a      <= '0;
         bus.alu_b      <= '0;
         bus.alu_op     <= '0;
         bus.rsp_valid  <= 1'b0;
         bus.rsp_result <= '0;
         bus.rsp_cout   <= 1'b0;
      end else begin
         arm_q <= 1'b0;
         case (state)
            IDLE: if (bus.req_valid) begin
               bus.alu_a  <= bus.req_a;
               bus.alu_b  <= bus.req_b;
               bus.alu_op <= bus.req_op;
               if (bus.req_op == 3'd7) begin
                  state <= ARM;
                  arm_q <= 1'b1;
                  cnt   <= CW'(MOD_CYCLES - 1);
               end else begin
                  state <= WAIT;
                  cnt   <= CW'(SIMPLE_CYCLES - 1);
               end
            end
            // arm_q drops back here, giving the ALU exactly one reset cycle
            ARM:  state <= WAIT;
            WAIT: if (cnt == '0) begin
               bus.rsp_result <= bus.alu_result;
               bus.rsp_cout   <= bus.alu_cout;
               bus.rsp_valid  <= 1'b1;
               state          <= HOLD;
            end else begin
               cnt <= cnt - CW'(1);
            end
            HOLD: if (bus.rsp_ready) begin
               bus.rsp_valid <= 1'b0;
               state         <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.req_ready = (state == IDLE);
   assign bus.busy      = (state != IDLE);
   assign bus.alu_rst   = reset | arm_q;
endmodule
